// File: rtl/uart_frame_gen.sv
// uart_frame_gen
// Transmit-side frame generator for the accelerometer UART link. On an
// accepted send_req it latches a 32-bit value and emits one frame, byte by
// byte, through a start/done handshake with a byte-level UART transmitter:
//   "%NOTI", SKIP_LEN x FILL_BYTE, 8 uppercase hex chars (MSN first), TERM_BYTE
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   send_req        request one frame; sampled only while idle
//   data_in         value to encode; latched when send_req is accepted
//   tx_done_tick    UART TX finished shifting out the current byte
//   tx_start        one-cycle pulse: UART TX loads tx_byte and starts
//   tx_byte         byte to transmit; held until the next byte is issued
//   busy            high while a frame is in progress
//   frame_done_tick one-cycle pulse in the first idle cycle after the frame
module uart_frame_gen #(
    parameter int unsigned SKIP_LEN  = 6,
    parameter logic [7:0]  FILL_BYTE = 8'h2E,
    parameter logic [7:0]  TERM_BYTE = 8'h0D
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        send_req,
    input  logic [31:0] data_in,
    input  logic        tx_done_tick,
    output logic        tx_start,
    output logic [7:0]  tx_byte,
    output logic        busy,
    output logic        frame_done_tick
);

    localparam int unsigned FRAME_LEN = 5 + SKIP_LEN + 8 + 1;
    localparam logic [4:0]  LAST_IDX  = 5'(FRAME_LEN - 1);
    localparam logic [4:0]  HEX_START = 5'(5 + SKIP_LEN);
    localparam logic [4:0]  HEX_END   = 5'(5 + SKIP_LEN + 8);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t      state;
    logic [4:0]  idx;
    logic [31:0] data_q;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) hex_char = 8'h30 + {4'h0, nib};
        else             hex_char = 8'h37 + {4'h0, nib};
    endfunction

    // Byte at position i of the frame for latched value d.
    function automatic logic [7:0] frame_byte(input logic [4:0] i, input logic [31:0] d);
        logic [2:0] k;
        logic [3:0] nib;
        frame_byte = TERM_BYTE;
        k          = 3'(i - HEX_START);
        nib        = 4'h0;
        if (i < 5'd5) begin
            case (i[2:0])
                3'd0:    frame_byte = 8'h25;
                3'd1:    frame_byte = 8'h4E;
                3'd2:    frame_byte = 8'h4F;
                3'd3:    frame_byte = 8'h54;
                default: frame_byte = 8'h49;
            endcase
        end else if (i < HEX_START) begin
            frame_byte = FILL_BYTE;
        end else if (i < HEX_END) begin
            case (k)
                3'd0:    nib = d[31:28];
                3'd1:    nib = d[27:24];
                3'd2:    nib = d[23:20];
                3'd3:    nib = d[19:16];
                3'd4:    nib = d[15:12];
                3'd5:    nib = d[11:8];
                3'd6:    nib = d[7:4];
                default: nib = d[3:0];
            endcase
            frame_byte = hex_char(nib);
        end
    endfunction

    // tx_start/tx_byte are loaded on the transition into SEND, so the
    // registered pulse is visible exactly during the SEND cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            data_q          <= '0;
            tx_start        <= 1'b0;
            tx_byte         <= '0;
            busy            <= 1'b0;
            frame_done_tick <= 1'b0;
        end else begin
            tx_start        <= 1'b0;
            frame_done_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (send_req) begin
                        data_q   <= data_in;
                        idx      <= '0;
                        tx_byte  <= frame_byte(5'd0, data_in);
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (tx_done_tick) begin
                        if (idx == LAST_IDX) begin
                            busy            <= 1'b0;
                            frame_done_tick <= 1'b1;
                            state           <= IDLE;
                        end else begin
                            idx      <= idx + 5'd1;
                            tx_byte  <= frame_byte(idx + 5'd1, data_q);
                            tx_start <= 1'b1;
                            state    <= SEND;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_gen.sv
module tb_uart_frame_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        send_req;
    logic [31:0] data_in;
    logic        tx_done_tick;
    logic        tx_start;
    logic [7:0]  tx_byte;
    logic        busy;
    logic        frame_done_tick;

    int compared = 0;
    int errors   = 0;

    uart_frame_gen #(
        .SKIP_LEN (6),
        .FILL_BYTE(8'h2E),
        .TERM_BYTE(8'h0D)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .send_req       (send_req),
        .data_in        (data_in),
        .tx_done_tick   (tx_done_tick),
        .tx_start       (tx_start),
        .tx_byte        (tx_byte),
        .busy           (busy),
        .frame_done_tick(frame_done_tick)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [7:0] byte_exp);
        check({tag, "_start"}, 0, {31'd0, tx_start}, 32'd0);
        check({tag, "_busy"}, 0, {31'd0, busy}, 32'd0);
        check({tag, "_fdone"}, 0, {31'd0, frame_done_tick}, 32'd0);
        check({tag, "_byte"}, 0, {24'd0, tx_byte}, {24'd0, byte_exp});
    endtask

    // Hand-laid frame: "%NOTI", six '.', the 8 given hex chars, CR.
    function automatic logic [7:0] exp_byte(input int i, input logic [63:0] hex);
        logic [39:0] pre;
        pre = "%NOTI";
        if (i < 5)       return pre[39-8*i -: 8];
        else if (i < 11) return 8'h2E;
        else if (i < 19) return hex[63-8*(i-11) -: 8];
        else             return 8'h0D;
    endfunction

    // Drives one frame with a TX model answering tx_done_tick 3 cycles after
    // each tx_start; optional disturbances are selected by byte index.
    task automatic run_frame(input logic [31:0] d, input logic [63:0] hex,
                             input int req_at, input int spur_at, input int abort_at,
                             input bit toggle, input bit keep_req, input bit started);
        logic [7:0] e;
        if (!started) begin
            data_in  = d;
            send_req = 1'b1;
            step();
            if (!keep_req) send_req = 1'b0;
        end
        for (int i = 0; i < 20; i++) begin
            e = exp_byte(i, hex);
            check("tx_start", i, {31'd0, tx_start}, 32'd1);
            check("tx_byte", i, {24'd0, tx_byte}, {24'd0, e});
            check("busy", i, {31'd0, busy}, 32'd1);
            check("fdone_early", i, {31'd0, frame_done_tick}, 32'd0);
            if (i == spur_at) tx_done_tick = 1'b1;
            step();
            tx_done_tick = 1'b0;
            check("start_pulse", i, {31'd0, tx_start}, 32'd0);
            check("byte_hold", i, {24'd0, tx_byte}, {24'd0, e});
            if (i == req_at) begin
                send_req = 1'b1;
                data_in  = 32'hDEADBEEF;
            end
            if (i == abort_at) begin
                reset = 1'b1;
                #1;
                check_idle("abort", 8'h00);
                return;
            end
            if (toggle) data_in = $urandom();
            step();
            send_req = keep_req;
            check("byte_hold2", i, {24'd0, tx_byte}, {24'd0, e});
            check("start_quiet", i, {31'd0, tx_start}, 32'd0);
            if (toggle) data_in = $urandom();
            step();
            check("start_quiet2", i, {31'd0, tx_start}, 32'd0);
            tx_done_tick = 1'b1;
            step();
            tx_done_tick = 1'b0;
        end
        check("fdone", 0, {31'd0, frame_done_tick}, 32'd1);
        check("busy_end", 0, {31'd0, busy}, 32'd0);
        check("start_end", 0, {31'd0, tx_start}, 32'd0);
        check("byte_end", 0, {24'd0, tx_byte}, 32'h0D);
        step();
        if (!keep_req) begin
            check("fdone_pulse", 0, {31'd0, frame_done_tick}, 32'd0);
            check("busy_after", 0, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        send_req     = 1'b0;
        data_in      = 32'h0;
        tx_done_tick = 1'b0;
        step();
        step();
        check_idle("reset", 8'h00);
        reset = 1'b0;
        step();
        check_idle("post_reset", 8'h00);

        // tx_done_tick while idle does nothing
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        check_idle("idle_done", 8'h00);

        // basic frame and hex boundaries
        run_frame(32'h1234ABCD, "1234ABCD", -1, -1, -1, 1'b0, 1'b0, 1'b0);
        check_idle("held_after", 8'h0D);
        run_frame(32'h09FA0F9A, "09FA0F9A", -1, -1, -1, 1'b0, 1'b0, 1'b0);
        run_frame(32'hFFFFFFFF, "FFFFFFFF", -1, -1, -1, 1'b0, 1'b0, 1'b0);

        // request while busy and data_in churn are ignored
        run_frame(32'h00000001, "00000001", 7, -1, -1, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_idle("no_queue", 8'h0D);
        end

        // tx_done_tick coincident with tx_start is ignored
        run_frame(32'hCAFEF00D, "CAFEF00D", -1, 4, -1, 1'b0, 1'b0, 1'b0);

        // reset during WAIT of byte 9 aborts the frame
        run_frame(32'h89ABCDEF, "89ABCDEF", -1, -1, 9, 1'b0, 1'b0, 1'b0);
        step();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        check_idle("in_reset", 8'h00);
        reset = 1'b0;
        step();
        tx_done_tick = 1'b1;
        step();
        tx_done_tick = 1'b0;
        check_idle("after_abort", 8'h00);
        run_frame(32'h89ABCDEF, "89ABCDEF", -1, -1, -1, 1'b0, 1'b0, 1'b0);

        // back-to-back frames with send_req held high
        run_frame(32'h5A5AA5A5, "5A5AA5A5", -1, -1, -1, 1'b0, 1'b1, 1'b0);
        run_frame(32'h5A5AA5A5, "5A5AA5A5", -1, -1, -1, 1'b0, 1'b0, 1'b1);
        check_idle("final", 8'h0D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
        $finish;
    end

endmodule

// File: doc/uart_frame_gen.md
Name: uart_frame_gen

Overview:
Transmit-side counterpart of the accelerometer UART frame parser. On request, it latches a 32-bit value and converts it to 8 uppercase ASCII hex characters. It then emits a complete frame, one byte at a time, through a start/done handshake with the byte-level UART transmitter. Frame layout is "%NOTI" preamble, SKIP_LEN filler bytes, 8 hex characters (most-significant nibble first), then one terminator byte. The frame is accepted unchanged by the receive-side parser.

Parameters:
SKIP_LEN, 6, number of filler bytes after the preamble (1..15)
FILL_BYTE, 8'h2E, value of each filler byte ('.')
TERM_BYTE, 8'h0D, trailing byte consumed and discarded by the receiver (CR)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
send_req  input  1  request to send one frame; sampled only when idle
data_in  input  32  value to encode; latched on the accepted send_req
tx_done_tick  input  1  one-cycle pulse from UART TX: current byte fully shifted out
tx_start  output  1  one-cycle pulse: UART TX must load tx_byte and start sending
tx_byte  output  8  byte to transmit; stable from tx_start until the matching tx_done_tick
busy  output  1  high while a frame is in progress (state != IDLE)
frame_done_tick  output  1  one-cycle pulse after the final byte completes

Behaviour:
- Reset is asynchronous, active-high, clock is clk.
  - On reset: state=IDLE, byte index=0, data latch=0, tx_start=0, tx_byte=8'h00, busy=0, frame_done_tick=0.
- Frame length N = 5 + SKIP_LEN + 8 + 1 (default 20). Byte index idx runs 0..N-1:
  - idx 0..4: 8'h25 8'h4E 8'h4F 8'h54 8'h49 ("%NOTI")
  - idx 5..4+SKIP_LEN: FILL_BYTE
  - next 8 bytes: hex chars of latched data, bits [31:28] first, [3:0] last
  - idx N-1: TERM_BYTE
- Hex conversion uses uppercase only: nibble 0-9 maps to 8'h30+n; nibble A-F maps to 8'h37+n (so 4'hA becomes 8'h41).
- States:
  - IDLE: if send_req, latch data_in, set idx=0, go to SEND.
  - SEND: drive tx_byte=byte(idx), pulse tx_start for exactly this one cycle, go to WAIT.
  - WAIT: stay until tx_done_tick.
    - On tx_done_tick with idx<N-1: idx++ and go to SEND.
    - On tx_done_tick with idx==N-1: go to IDLE and assert frame_done_tick in the next cycle.
- All outputs are registered.
- Latency:
  - send_req accepted at cycle T gives tx_start at T+1.
  - tx_done_tick at cycle U (not the last byte) gives the next tx_start at U+1.
  - frame_done_tick is high in the first IDLE cycle; busy=0 in that same cycle.
- tx_byte holds its value until the next SEND; it is not cleared between bytes.
- Ignored inputs:
  - send_req is ignored while busy; there is no queuing.
  - data_in changes after latching have no effect on the frame in progress.
  - tx_done_tick is ignored in IDLE and SEND; only WAIT responds. This also covers a tx_done_tick coincident with tx_start.
- Back-to-back frames: send_req high in the frame_done_tick cycle is accepted (state is IDLE). The next tx_start follows one cycle later.
- Reset mid-frame aborts immediately. No further tx_start or frame_done_tick is issued, and the partial frame is discarded.
  - The receiver's preamble search resynchronises on the next frame.
- idx counter is 5 bits wide, and N must be at most 32.

Test Plan:
1. data_in=32'h1234ABCD, send_req pulse; TX model returns tx_done_tick 3 cycles after each tx_start -> exactly 20 tx_start pulses carrying 25 4E 4F 54 49, 2E x6, 31 32 33 34 41 42 43 44, 0D. One frame_done_tick, then busy=0. Loop the output into uart_parse: drdy_tick fires with ascii_out="1234ABCD".
2. Hex boundaries: data_in=32'h09FA0F9A -> hex bytes 30 39 46 41 30 46 39 41. data_in=32'hFFFFFFFF -> eight 8'h46.
3. Busy rules: second send_req with data_in=32'hDEADBEEF at byte 7 of a frame for 32'h00000001 -> ignored, frame encodes 00000001, only one frame_done_tick. data_in toggling mid-frame -> no effect.
4. Spurious handshakes: tx_done_tick in IDLE -> no output change. tx_done_tick in the same cycle as tx_start -> ignored, and tx_byte stays held until a later tx_done_tick.
5. Reset asserted mid-frame (during WAIT of idx 9) -> all outputs 0 immediately, no further tx_start. A new send_req after deassertion yields a full 20-byte frame from idx 0.
6. Back-to-back: send_req held high continuously -> next frame's first tx_start (8'h25) occurs 1 cycle after frame_done_tick. Two complete frames with identical framing.
